// File: rtl/decode_ctrl_pkg.sv
// Shared definitions for the MIPS decode/control stage: opcode and function
// encodings, ALU-op and branch-compare codes, FSM states and the control bundle.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN adds the TRAP state.
package decode_ctrl_pkg;

  localparam int CTRL_ALUOP_W = 6;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_LWU   = 6'h27;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation codes understood by the EX stage
  localparam logic [CTRL_ALUOP_W-1:0] ALU_RTYPE = 6'h00;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_ADDI  = 6'h02;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_ADDIU = 6'h03;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_BEQ   = 6'h06;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_BNE   = 6'h07;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_ANDI  = 6'h08;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_ORI   = 6'h09;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_XORI  = 6'h0A;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_JUMP  = 6'h0B;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SLTI  = 6'h0C;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SLTIU = 6'h0D;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_LUI   = 6'h0E;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SRL   = 6'h12;
  localparam logic [CTRL_ALUOP_W-1:0] ALU_SRLV  = 6'h14;

  // Branch comparison codes
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
`ifdef DECODE_ILLEGAL_TRAP_EN
    ST_HALTED = 2'd2,
    ST_TRAP   = 2'd3
`else
    ST_HALTED = 2'd2
`endif
  } state_e;

  typedef struct packed {
    logic                    alu_b_sel;
    logic                    mem_write;
    logic                    mem_read;
    logic                    reg_write;
    logic                    jump_reg_sel;
    logic [1:0]              reg_dst;
    logic [1:0]              byte_sig;
    logic [1:0]              mem_to_reg;
    logic [2:0]              branch_comp;
    logic [CTRL_ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // True for every R-type function code the core implements
  function automatic logic is_rtype_funct(input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR, FN_JALR,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
      FN_SLT, FN_SLTU: ok = 1'b1;
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when opcode (and function, for R-type) is a defined encoding
  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    logic ok;
    case (opcode)
      OP_RTYPE: ok = is_rtype_funct(funct);
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU,
      OP_LHU, OP_LWU, OP_SB, OP_SH, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/decode_ctrl_stage_decode.sv
// ctrl_decode_comb: purely combinational opcode/function -> control bundle
// decode. Also reports whether the instruction reads rt as a source, which
// the hazard logic needs. Undefined encodings yield an all-zero (NOP) bundle.
module ctrl_decode_comb
  import decode_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_uses_rt
);

  // Decode the instruction class into control signals
  always_comb begin
    o_ctrl    = '0;
    o_uses_rt = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_uses_rt = 1'b1;
        case (i_funct)
          FN_JR: begin
            o_ctrl.jump_reg_sel = 1'b1;
            o_ctrl.alu_op       = ALU_JUMP;
          end
          FN_JALR: begin
            o_ctrl.jump_reg_sel = 1'b1;
            o_ctrl.alu_op       = ALU_JUMP;
            o_ctrl.reg_write    = 1'b1;
            o_ctrl.reg_dst      = 2'b01;
            o_ctrl.mem_to_reg   = 2'b01;
          end
          default: begin
            if (is_rtype_funct(i_funct)) begin
              o_ctrl.reg_write  = 1'b1;
              o_ctrl.reg_dst    = 2'b01;
              o_ctrl.mem_to_reg = 2'b10;
              if (i_funct == FN_SRL) begin
                o_ctrl.alu_op = ALU_SRL;
              end else if (i_funct == FN_SRLV) begin
                o_ctrl.alu_op = ALU_SRLV;
              end else begin
                o_ctrl.alu_op = ALU_RTYPE;
              end
            end else begin
              o_ctrl = '0;
            end
          end
        endcase
      end
      OP_J: o_ctrl.alu_op = ALU_JUMP;
      OP_JAL: begin
        o_ctrl.alu_op     = ALU_JUMP;
        o_ctrl.reg_dst    = 2'b10;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 2'b01;
      end
      OP_BEQ: begin
        o_uses_rt          = 1'b1;
        o_ctrl.branch_comp = BR_EQ;
        o_ctrl.alu_op      = ALU_BEQ;
      end
      OP_BNE: begin
        o_uses_rt          = 1'b1;
        o_ctrl.branch_comp = BR_NE;
        o_ctrl.alu_op      = ALU_BNE;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: begin
        o_ctrl.alu_b_sel  = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 2'b10;
        case (i_opcode)
          OP_ADDI:  o_ctrl.alu_op = ALU_ADDI;
          OP_ADDIU: o_ctrl.alu_op = ALU_ADDIU;
          OP_ANDI:  o_ctrl.alu_op = ALU_ANDI;
          OP_ORI:   o_ctrl.alu_op = ALU_ORI;
          OP_XORI:  o_ctrl.alu_op = ALU_XORI;
          OP_SLTI:  o_ctrl.alu_op = ALU_SLTI;
          OP_SLTIU: o_ctrl.alu_op = ALU_SLTIU;
          default:  o_ctrl.alu_op = ALU_LUI;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        o_ctrl.alu_b_sel = 1'b1;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALU_ADDI;
        case (i_opcode)
          OP_LH, OP_LHU: o_ctrl.byte_sig = 2'b01;
          OP_LB, OP_LBU: o_ctrl.byte_sig = 2'b10;
          default:       o_ctrl.byte_sig = 2'b00;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        o_uses_rt        = 1'b1;
        o_ctrl.alu_b_sel = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_op    = ALU_ADDI;
        case (i_opcode)
          OP_SH:   o_ctrl.byte_sig = 2'b01;
          OP_SB:   o_ctrl.byte_sig = 2'b10;
          default: o_ctrl.byte_sig = 2'b00;
        endcase
      end
      default: begin
        o_ctrl    = '0;
        o_uses_rt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered decoder and ID/EX control register with
// load-use bubbles, branch flush and a halt/drain FSM for the debug unit.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN -- undefined encodings in RUN
// move to a TRAP state (left only by reset) and raise o_illegal.
module decode_ctrl_stage
  import decode_ctrl_pkg::*;
#(
  parameter int ALUOP_W      = 6,
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        i_instr,
  input  logic               i_valid,
  input  logic               i_ex_memread,
  input  logic [REG_W-1:0]   i_ex_rt,
  input  logic               i_branch_taken,
  input  logic               i_halt,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic               o_illegal,
`endif
  output logic               o_stall_if,
  output logic               o_flush_if,
  output logic               o_halted,
  output logic               o_valid,
  output logic               o_alu_b_sel,
  output logic               o_mem_write,
  output logic               o_mem_read,
  output logic               o_reg_write,
  output logic               o_jump_reg_sel,
  output logic [1:0]         o_reg_dst,
  output logic [1:0]         o_byte_sig,
  output logic [1:0]         o_mem_to_reg,
  output logic [2:0]         o_branch_comp,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [REG_W-1:0]   o_rs,
  output logic [REG_W-1:0]   o_rt,
  output logic [REG_W-1:0]   o_rd
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  state_e           state_r, state_nxt_s;
  logic [3:0]       cnt_r, cnt_nxt_s;
  ctrl_t            dec_s, ctrl_r;
  logic             uses_rt_s, hazard_s, load_s, valid_r, halted_r;
  logic [REG_W-1:0] rs_s, rt_s, rd_s, rs_r, rt_r, rd_r;
  logic             unused_shamt_s;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic             trap_s, illegal_r;
`endif

  assign rs_s           = REG_W'(i_instr[25:21]);
  assign rt_s           = REG_W'(i_instr[20:16]);
  assign rd_s           = REG_W'(i_instr[15:11]);
  assign unused_shamt_s = ^i_instr[10:6];

  ctrl_decode_comb u_dec (
    .i_opcode  (i_instr[31:26]),
    .i_funct   (i_instr[5:0]),
    .o_ctrl    (dec_s),
    .o_uses_rt (uses_rt_s)
  );

  // Load-use hazard: EX load writes a register this instruction reads
  assign hazard_s = i_valid && i_ex_memread && (i_ex_rt != '0) &&
                    ((i_ex_rt == rs_s) || (uses_rt_s && (i_ex_rt == rt_s)));

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Trap only on an instruction that would otherwise be decoded this cycle
  assign trap_s = (state_r == ST_RUN) && i_valid && !i_branch_taken && !i_halt &&
                  !hazard_s && !is_legal(i_instr[31:26], i_instr[5:0]);
  assign load_s = (state_r == ST_RUN) && i_valid && !i_branch_taken && !i_halt &&
                  !hazard_s && !trap_s;
  assign o_stall_if = !i_branch_taken &&
                      ((state_r != ST_RUN) || i_halt || hazard_s || trap_s);
`else
  assign load_s = (state_r == ST_RUN) && i_valid && !i_branch_taken && !i_halt &&
                  !hazard_s;
  assign o_stall_if = !i_branch_taken &&
                      ((state_r != ST_RUN) || i_halt || hazard_s);
`endif
  assign o_flush_if = i_branch_taken;

  // Halt/drain FSM next state and drain counter
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (i_halt) begin
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = DRAIN_INIT;
`ifdef DECODE_ILLEGAL_TRAP_EN
        end else if (trap_s) begin
          state_nxt_s = ST_TRAP;
          cnt_nxt_s   = 4'd0;
`endif
        end else begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 4'd0;
        end
      end
      ST_DRAIN: begin
        if (!i_halt) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = ST_HALTED;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      ST_HALTED: begin
        if (!i_halt) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      ST_TRAP: state_nxt_s = ST_TRAP;
`endif
      default: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // ID/EX register and FSM state; bubbles clear every field
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_RUN;
      cnt_r    <= 4'd0;
      ctrl_r   <= '0;
      valid_r  <= 1'b0;
      rs_r     <= '0;
      rt_r     <= '0;
      rd_r     <= '0;
      halted_r <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_r <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
`ifdef DECODE_ILLEGAL_TRAP_EN
      halted_r  <= (state_nxt_s == ST_HALTED) || (state_nxt_s == ST_TRAP);
      illegal_r <= (state_nxt_s == ST_TRAP);
`else
      halted_r  <= (state_nxt_s == ST_HALTED);
`endif
      if (load_s) begin
        ctrl_r  <= dec_s;
        valid_r <= 1'b1;
        rs_r    <= rs_s;
        rt_r    <= rt_s;
        rd_r    <= rd_s;
      end else begin
        ctrl_r  <= '0;
        valid_r <= 1'b0;
        rs_r    <= '0;
        rt_r    <= '0;
        rd_r    <= '0;
      end
    end
  end

  assign o_valid        = valid_r;
  assign o_halted       = halted_r;
  assign o_alu_b_sel    = ctrl_r.alu_b_sel;
  assign o_mem_write    = ctrl_r.mem_write;
  assign o_mem_read     = ctrl_r.mem_read;
  assign o_reg_write    = ctrl_r.reg_write;
  assign o_jump_reg_sel = ctrl_r.jump_reg_sel;
  assign o_reg_dst      = ctrl_r.reg_dst;
  assign o_byte_sig     = ctrl_r.byte_sig;
  assign o_mem_to_reg   = ctrl_r.mem_to_reg;
  assign o_branch_comp  = ctrl_r.branch_comp;
  assign o_alu_op       = ALUOP_W'(ctrl_r.alu_op);
  assign o_rs           = rs_r;
  assign o_rt           = rt_r;
  assign o_rd           = rd_r;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign o_illegal      = illegal_r;
`endif

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed self-checking bench for decode_ctrl_stage (DRAIN_CYCLES = 3).
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_instr;
  logic        i_valid, i_ex_memread, i_branch_taken, i_halt;
  logic [4:0]  i_ex_rt;
  logic        o_stall_if, o_flush_if, o_halted, o_valid;
  logic        o_alu_b_sel, o_mem_write, o_mem_read, o_reg_write, o_jump_reg_sel;
  logic [1:0]  o_reg_dst, o_byte_sig, o_mem_to_reg;
  logic [2:0]  o_branch_comp;
  logic [5:0]  o_alu_op;
  logic [4:0]  o_rs, o_rt, o_rd;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        o_illegal;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [31:0] vec_instr [7];
  logic [19:0] vec_ctrl  [7];

  always #5 clk = ~clk;

  decode_ctrl_stage #(.ALUOP_W(6), .REG_W(5), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .i_instr(i_instr), .i_valid(i_valid),
    .i_ex_memread(i_ex_memread), .i_ex_rt(i_ex_rt),
    .i_branch_taken(i_branch_taken), .i_halt(i_halt),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .o_illegal(o_illegal),
`endif
    .o_stall_if(o_stall_if), .o_flush_if(o_flush_if), .o_halted(o_halted),
    .o_valid(o_valid), .o_alu_b_sel(o_alu_b_sel), .o_mem_write(o_mem_write),
    .o_mem_read(o_mem_read), .o_reg_write(o_reg_write),
    .o_jump_reg_sel(o_jump_reg_sel), .o_reg_dst(o_reg_dst),
    .o_byte_sig(o_byte_sig), .o_mem_to_reg(o_mem_to_reg),
    .o_branch_comp(o_branch_comp), .o_alu_op(o_alu_op),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected bundle: {alu_b, mem_wr, mem_rd, reg_wr, jr_sel, reg_dst, byte_sig, mem_to_reg, br, alu_op}
  function automatic logic [19:0] mk(input logic ab, input logic mw, input logic mr,
                                     input logic rw, input logic jr, input logic [1:0] rd,
                                     input logic [1:0] bs, input logic [1:0] m2r,
                                     input logic [2:0] bc, input logic [5:0] op);
    return {ab, mw, mr, rw, jr, rd, bs, m2r, bc, op};
  endfunction

  function automatic logic [31:0] obs();
    return {12'd0, o_alu_b_sel, o_mem_write, o_mem_read, o_reg_write, o_jump_reg_sel,
            o_reg_dst, o_byte_sig, o_mem_to_reg, o_branch_comp, o_alu_op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_instr[0] = 32'h84A60010; vec_ctrl[0] = mk(1'b1,1'b0,1'b1,1'b1,1'b0,2'b00,2'b01,2'b00,3'd0,6'h02); // LH
    vec_instr[1] = 32'hA0A60000; vec_ctrl[1] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,3'd0,6'h02); // SB
    vec_instr[2] = 32'h14220003; vec_ctrl[2] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'd2,6'h07); // BNE
    vec_instr[3] = 32'h0C000010; vec_ctrl[3] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,2'b00,2'b01,3'd0,6'h0B); // JAL
    vec_instr[4] = 32'h03E00008; vec_ctrl[4] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,3'd0,6'h0B); // JR
    vec_instr[5] = 32'h00031042; vec_ctrl[5] = mk(1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b00,2'b10,3'd0,6'h12); // SRL
    vec_instr[6] = 32'h10220003; vec_ctrl[6] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'd1,6'h06); // BEQ

    reset = 1'b1; i_instr = 32'd0; i_valid = 1'b0; i_ex_memread = 1'b0;
    i_ex_rt = 5'd0; i_branch_taken = 1'b0; i_halt = 1'b0;
    tick(); tick();
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_halted", 32'(o_halted), 32'd0);
    check_eq("rst_ctrl", obs(), 32'd0);
    check_eq("rst_stall", 32'(o_stall_if), 32'd0);
    reset = 1'b0;

    // ADDI $t0, $zero, 5
    i_instr = 32'h20080005; i_valid = 1'b1; #1;
    check_eq("addi_stall", 32'(o_stall_if), 32'd0);
    check_eq("addi_flush", 32'(o_flush_if), 32'd0);
    tick();
    check_eq("addi_ctrl", obs(), 32'(mk(1'b1,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b10,3'd0,6'h02)));
    check_eq("addi_rt", 32'(o_rt), 32'd8);
    check_eq("addi_valid", 32'(o_valid), 32'd1);

    // Load-use: ADD $10,$8,$9 behind a load of $8
    i_instr = 32'h01095020; i_ex_memread = 1'b1; i_ex_rt = 5'd8; #1;
    check_eq("lu_stall", 32'(o_stall_if), 32'd1);
    tick();
    check_eq("lu_bubble_valid", 32'(o_valid), 32'd0);
    check_eq("lu_bubble_ctrl", obs(), 32'd0);
    check_eq("lu_bubble_rs", 32'(o_rs), 32'd0);
    i_ex_memread = 1'b0; #1;
    check_eq("lu_release", 32'(o_stall_if), 32'd0);
    tick();
    check_eq("add_ctrl", obs(), 32'(mk(1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b00,2'b10,3'd0,6'h00)));
    check_eq("add_rs", 32'(o_rs), 32'd8);
    check_eq("add_rd", 32'(o_rd), 32'd10);

    // Hazard boundaries: $zero never hazards; rt only counts for R/branch/store
    i_instr = 32'h00005020; i_ex_memread = 1'b1; i_ex_rt = 5'd0; #1;
    check_eq("lu_zero_reg", 32'(o_stall_if), 32'd0);
    i_instr = 32'hAC080004; i_ex_rt = 5'd8; #1;
    check_eq("lu_store_rt", 32'(o_stall_if), 32'd1);
    i_instr = 32'h20080005; #1;
    check_eq("lu_imm_rt", 32'(o_stall_if), 32'd0);
    i_ex_memread = 1'b0;

    // Decode table
    for (int i = 0; i < 7; i++) begin
      i_instr = vec_instr[i];
      tick();
      check_eq($sformatf("dec_%0d", i), obs(), 32'(vec_ctrl[i]));
    end

    // Flush overrides stall
    i_instr = 32'h01095020; i_ex_memread = 1'b1; i_ex_rt = 5'd8; i_branch_taken = 1'b1; #1;
    check_eq("fl_flush", 32'(o_flush_if), 32'd1);
    check_eq("fl_stall", 32'(o_stall_if), 32'd0);
    tick();
    check_eq("fl_bubble", 32'(o_valid), 32'd0);
    i_branch_taken = 1'b0; i_ex_memread = 1'b0;

    // Invalid IF/ID loads a bubble
    i_instr = 32'h20080005; i_valid = 1'b0;
    tick();
    check_eq("inv_bubble", 32'(o_valid), 32'd0);
    i_valid = 1'b1;

    // Halt and drain: halted after DRAIN_CYCLES+1 edges
    i_halt = 1'b1; #1;
    check_eq("halt_stall", 32'(o_stall_if), 32'd1);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_eq($sformatf("drain_halted_%0d", e), 32'(o_halted), 32'd0);
      check_eq($sformatf("drain_bubble_%0d", e), 32'(o_valid), 32'd0);
    end
    tick();
    check_eq("halted", 32'(o_halted), 32'd1);
    i_halt = 1'b0; #1;
    check_eq("halted_stall", 32'(o_stall_if), 32'd1);
    tick();
    check_eq("resume_halted", 32'(o_halted), 32'd0);
    check_eq("resume_stall", 32'(o_stall_if), 32'd0);
    tick();
    check_eq("resume_valid", 32'(o_valid), 32'd1);

    // Halt dropped mid-drain returns to RUN
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0; #1;
    check_eq("abort_drain_stall", 32'(o_stall_if), 32'd1);
    tick();
    check_eq("abort_run_stall", 32'(o_stall_if), 32'd0);
    tick();
    check_eq("abort_valid", 32'(o_valid), 32'd1);

    // Reset during drain
    i_halt = 1'b1;
    tick(); tick();
    reset = 1'b1; i_halt = 1'b0;
    tick();
    check_eq("rdr_valid", 32'(o_valid), 32'd0);
    check_eq("rdr_ctrl", obs(), 32'd0);
    check_eq("rdr_halted", 32'(o_halted), 32'd0);
    reset = 1'b0; #1;
    check_eq("rdr_run", 32'(o_stall_if), 32'd0);
    tick();
    check_eq("rdr_decode", 32'(o_valid), 32'd1);

    // Flush during drain: IF/ID cleared, draining continues
    i_halt = 1'b1;
    tick();
    i_branch_taken = 1'b1; #1;
    check_eq("fd_flush", 32'(o_flush_if), 32'd1);
    check_eq("fd_stall", 32'(o_stall_if), 32'd0);
    tick();
    i_branch_taken = 1'b0; #1;
    check_eq("fd_stall_again", 32'(o_stall_if), 32'd1);
    tick();
    check_eq("fd_not_yet", 32'(o_halted), 32'd0);
    tick();
    check_eq("fd_halted", 32'(o_halted), 32'd1);
    i_halt = 1'b0;
    tick();

    // Undefined encodings
`ifdef DECODE_ILLEGAL_TRAP_EN
    i_instr = 32'hFC000000; #1;
    check_eq("ill_stall", 32'(o_stall_if), 32'd1);
    tick();
    check_eq("ill_flag", 32'(o_illegal), 32'd1);
    check_eq("ill_halted", 32'(o_halted), 32'd1);
    check_eq("ill_bubble", 32'(o_valid), 32'd0);
    i_instr = 32'h20080005;
    tick(); tick();
    check_eq("ill_persist", 32'(o_illegal), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("ill_reset", 32'(o_illegal), 32'd0);
    reset = 1'b0;
`else
    i_instr = 32'hFC000000; #1;
    check_eq("ill_stall", 32'(o_stall_if), 32'd0);
    tick();
    check_eq("ill_nop", obs(), 32'd0);
    check_eq("ill_not_halted", 32'(o_halted), 32'd0);
    i_instr = 32'h0000003F;
    tick();
    check_eq("ill_funct_nop", obs(), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered instruction decoder and ID/EX control register for the pipelined MIPS core. It decodes the IF/ID instruction into the standard control bundle and registers it, together with the register addresses, into the ID/EX stage. It inserts bubbles for load-use hazards, flushes on taken branches and jumps, and runs a halt/drain state machine for the debug unit. It replaces the purely combinational control decoder; its decode encodings are unchanged.

## Interface
- `ALUOP_W`, 6: ALU operation code width.
- `REG_W`, 5: register address width.
- `DRAIN_CYCLES`, 3: bubbles inserted after a halt request before the halted state is reached (1–15).
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `i_instr` in 32: IF/ID instruction.
- `i_valid` in 1: IF/ID holds a valid instruction.
- `i_ex_memread` in 1: instruction now in EX is a load.
- `i_ex_rt` in `REG_W`: destination register of that load.
- `i_branch_taken` in 1: EX resolved a taken branch or jump.
- `i_halt` in 1: debug halt request, level-sensitive.
- `o_stall_if` out 1: hold PC and IF/ID (combinational).
- `o_flush_if` out 1: clear IF/ID (combinational).
- `o_halted` out 1: core halted, pipeline drained (registered).
- `o_valid` out 1: ID/EX entry valid.
- `o_alu_b_sel`, `o_mem_write`, `o_mem_read`, `o_reg_write`, `o_jump_reg_sel` out 1 each: control signals.
- `o_reg_dst`, `o_byte_sig`, `o_mem_to_reg` out 2 each: control signals.
- `o_branch_comp` out 3: 1 = BEQ, 2 = BNE.
- `o_alu_op` out `ALUOP_W`: ALU operation.
- `o_rs`, `o_rt`, `o_rd` out `REG_W` each: instruction fields [25:21], [20:16], [15:11].

## Operation
- **Decode:** the opcode/function mapping matches the existing control unit.
  - R-type: reg_write=1, reg_dst=01, mem_to_reg=10; ALU op SRL 0x12 / SRLV 0x14 / else 0.
  - JR/JALR: jump_reg_sel=1, ALU op 0x0B; JALR also sets reg_write, reg_dst=01, mem_to_reg=01.
  - J/JAL: ALU op 0x0B; JAL also sets reg_dst=10, reg_write=1, mem_to_reg=01.
  - BEQ/BNE: branch_comp 1/2, ALU op 0x06/0x07.
  - ADDI/ADDIU/ANDI/ORI/XORI/SLTI/SLTIU/LUI: alu_b_sel=1, reg_write=1, mem_to_reg=10, with the matching ALU op.
  - Loads (LB/LH/LW/LBU/LHU/LWU): alu_b_sel, mem_read, reg_write, ALU op ADDI. byte_sig is 01 for halfword, 10 for byte, 00 for word.
  - Stores (SB/SH/SW): alu_b_sel, mem_write, ALU op ADDI, byte_sig as for loads.
  - Any other opcode decodes to a NOP.
- **Bubble:** all control outputs 0 and `o_valid`=0. `o_rs`/`o_rt`/`o_rd` are also 0.
- **Load-use hazard:** asserted when `i_valid` and `i_ex_memread` and `i_ex_rt`≠0 and `i_ex_rt` equals rs, or equals rt for R-type, branch or store instructions.
  - Effect: `o_stall_if`=1 for that cycle and ID/EX loads a bubble.
  - Exactly one stall cycle per hazard.
- **Flush:** when `i_branch_taken`=1, `o_flush_if`=1 and ID/EX loads a bubble. Flush overrides a stall in the same cycle (`o_stall_if`=0).
- **FSM states:**
  - RUN: normal decode.
  - DRAIN: ID/EX loads a bubble every cycle; `o_stall_if`=1; a counter counts down from `DRAIN_CYCLES`-1.
  - HALTED: `o_halted`=1, `o_stall_if`=1, ID/EX holds a bubble.
- **FSM transitions:**
  - RUN→DRAIN when `i_halt`=1.
  - DRAIN→HALTED when the counter reaches 0.
  - DRAIN→RUN if `i_halt` drops during DRAIN.
  - HALTED→RUN when `i_halt`=0.
- **Priority:** reset > flush > halt/drain > load-use stall > normal decode.

## Timing
- Decode latency is 1 cycle: `i_instr` sampled at edge N appears on `o_*` after edge N.
- `o_stall_if` and `o_flush_if` are combinational from the current inputs and state; there is no registered path.
- Reset: state RUN, counter 0, all registered outputs 0 (bubble), `o_halted`=0.
- Reset mid-drain returns to RUN on the next edge.
- When `i_valid`=0, ID/EX loads a bubble.
- A flush during DRAIN still clears IF/ID; draining continues.
- Halt to `o_halted` takes `DRAIN_CYCLES`+1 edges.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN`, when defined:
  - An undefined opcode, or an undefined R-type function, with `i_valid`=1 in RUN moves the FSM to TRAP and drives output `o_illegal` (1 bit, registered).
  - TRAP behaves like HALTED and is left only by reset.
- Without the macro: undefined encodings decode as NOP, there is no `o_illegal` port, and there is no TRAP state.

## Structure
- Package `decode_ctrl_pkg` holds:
  - opcode and function localparams;
  - ALU-op and branch-comparison codes;
  - FSM state enum;
  - the control-bundle packed struct.
- One sub-module, `ctrl_decode_comb`: purely combinational instruction→bundle decode, reusable by the single-cycle core.

## Test plan
- **Decode:** ADDI 0x20080005 → next cycle `o_alu_b_sel`=1, `o_reg_write`=1, `o_mem_to_reg`=10, `o_alu_op`=0x02, `o_rt`=8.
- **Load-use:** EX load with `i_ex_rt`=8, ID holds ADD with rs=8 → `o_stall_if`=1 for one cycle, bubble in ID/EX, then the ADD is decoded.
- **Flush over stall:** `i_branch_taken`=1 together with a load-use hazard → `o_flush_if`=1, `o_stall_if`=0, bubble.
- **Halt/drain:** `i_halt` held high, `DRAIN_CYCLES`=3 → 3 bubbles, `o_halted`=1 on the 4th edge; `i_halt` low → RUN next edge.
- **Reset during drain:** `reset` asserted in DRAIN → next cycle state RUN, all outputs 0.
- **Illegal opcode:** opcode 0x3F with the macro defined → `o_illegal`=1 and TRAP persists until reset; without the macro → NOP bubble.
